spr_multi_ctrl: RTL
===================

Name: spr_multi_ctrl

Overview:
- Parametrised successor to the single-sprite compositor.
- Overlays up to NSPR sprites on the VRAM background, selecting per pixel with fixed priority. Each sprite supports a frame (animation) index, horizontal flip and scroll compensation.
- Sprite attributes are double-buffered and swap only at frame end, so sprites do not tear.
- Produces a per-frame bounding-box collision mask against sprite 0 (the player). Sits between the VGA timing controller and the RGB output pins.

Parameters:
NSPR, 4, number of sprites; index 0 has highest priority
SPR_W, 32, sprite width in pixels; power of two
SPR_H, 32, sprite height in pixels; power of two
NFRAME, 8, frames in the shared sprite ROM; power of two
CW, 9, colour width (3R3G3B)
KEY, 0, transparent colour value

Ports:
clk_25mhz  in  1  pixel clock
RST  in  1  synchronous reset, active-high
pixel_x  in  10  active-area scan x
pixel_y  in  10  active-area scan y
vga_block  in  1  active-area flag
vga_end  in  1  one-cycle end-of-frame pulse
bg_pos  in  10  background scroll offset
vram_dat  in  CW  background colour, valid one cycle after pixel_x/pixel_y
cfg_we  in  1  attribute write strobe
cfg_sel  in  clog2(NSPR)  sprite index written
cfg_x  in  10  sprite world x
cfg_y  in  10  sprite screen y
cfg_frame  in  clog2(NFRAME)  frame index
cfg_en  in  1  sprite enable
cfg_flip  in  1  horizontal mirror
rom_adr  out  clog2(NFRAME*SPR_W*SPR_H)  shared sprite ROM address, combinational
rom_dat  in  CW  ROM data, one-cycle read latency
vga_dat  out  CW  composited colour, registered
coll_flags  out  NSPR  sprites whose box overlapped sprite 0 last frame

Behaviour:
- Reset (RST sampled high at clk edge):
  - All pending and active attributes are cleared: en=0, x=y=frame=flip=0.
  - vga_dat=0, coll_flags=0, collision accumulator=0, pipeline registers=0.
- Attribute write: cfg_we=1 writes all five fields of pending[cfg_sel] at the edge. cfg_sel>=NSPR is ignored.
- Frame swap: on vga_end, active <= pending for every sprite, using pre-edge pending contents. A write in the same cycle as vga_end reaches pending only and becomes active at the next vga_end.
- Hit test, stage 0, combinational, per sprite i:
  - dx = pixel_x + bg_pos - x_i, 11-bit modulo arithmetic.
  - dy = pixel_y - y_i, 11-bit modulo arithmetic.
  - hit_i = en_i & vga_block & (dx < SPR_W) & (dy < SPR_H).
  - Sprites partially off the left or top edge clip correctly; no wrap artefacts.
- Winner is the lowest index with hit_i=1.
- Local x = flip ? SPR_W-1-dx : dx.
- rom_adr = {frame_w, dy[log2 SPR_H-1:0], localx[log2 SPR_W-1:0]}. When there is no winner, rom_adr=0.
- Stage 1 registers: any_hit, vga_block.
- Output edge at the end of stage 1:
  - If the registered vga_block=0, vga_dat <= 0.
  - Else if any_hit and rom_dat != KEY, vga_dat <= rom_dat.
  - Else vga_dat <= vram_dat.
  - A transparent winner pixel shows background. Lower-priority sprites are not consulted.
- Latency: vga_dat reflects the pixel presented 2 edges earlier. The pipeline is free-running, with no stall.
- Collision:
  - Each cycle, for i>=1: acc[i] <= acc[i] | (hit_0 & hit_i). This uses bounding boxes, ignores transparency and respects en.
  - On vga_end: coll_flags <= acc | current-cycle term, then acc <= 0.
  - coll_flags bit 0 is always 0. coll_flags holds its value for the whole following frame.
- Reset asserted mid-frame clears everything at that edge. Output is black and there are no sprites until new writes are made and a vga_end occurs.

Test Plan:
1. Reset, then write sprite 0 (x=100, y=50, en=1, frame 0) without a vga_end → no sprite pixels at any pixel. After vga_end, at pixel (100,50) rom_adr=0, and at (131,81) rom_adr=1023. vga_dat equals rom_dat 2 cycles later.
2. Set bg_pos=40, sprite x=60 → hit at pixel_x 20..51. With x=20 and bg_pos=40 → visible columns 0..11 only, local x 20..31 at those columns.
3. Sprites 0 and 1 both at (200,100); ROM returns KEY for sprite 0's pixel → vga_dat=vram_dat, not sprite 1's colour. With a non-KEY colour → sprite 0's colour.
4. flip=1, frame=3 at pixel (x,y) → rom_adr = 3*1024+31. At (x+31,y) → rom_adr = 3*1024+0.
5. Sprite 2 box overlaps sprite 0's box; sprite 3 is disjoint → after vga_end coll_flags=4'b0100. In the next frame with no overlap → 4'b0000 after the following vga_end.
6. cfg_we coincident with vga_end → the old value is active for one more frame and the new value applies after the second vga_end. RST pulsed mid-line → vga_dat=0 and coll_flags=0 on the next cycle.

Source files
------------

// File: rtl/spr_multi_ctrl.sv
// Multi-sprite compositor: overlays NSPR double-buffered sprites on the VRAM background
// with fixed priority, and reports per-frame bounding-box collisions against sprite 0.
module spr_multi_ctrl #(
  parameter int NSPR   = 4,
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int NFRAME = 8,
  parameter int CW     = 9,
  parameter int KEY    = 0
) (
  input  logic                                     clk_25mhz,
  input  logic                                     RST,
  input  logic [9:0]                               pixel_x,
  input  logic [9:0]                               pixel_y,
  input  logic                                     vga_block,
  input  logic                                     vga_end,
  input  logic [9:0]                               bg_pos,
  input  logic [CW-1:0]                            vram_dat,
  input  logic                                     cfg_we,
  input  logic [$clog2(NSPR)-1:0]                  cfg_sel,
  input  logic [9:0]                               cfg_x,
  input  logic [9:0]                               cfg_y,
  input  logic [$clog2(NFRAME)-1:0]                cfg_frame,
  input  logic                                     cfg_en,
  input  logic                                     cfg_flip,
  output logic [$clog2(NFRAME*SPR_W*SPR_H)-1:0]    rom_adr,
  input  logic [CW-1:0]                            rom_dat,
  output logic [CW-1:0]                            vga_dat,
  output logic [NSPR-1:0]                          coll_flags
);

  localparam int SELW = $clog2(NSPR);
  localparam int FRW  = $clog2(NFRAME);
  localparam int WB   = $clog2(SPR_W);
  localparam int HB   = $clog2(SPR_H);

  typedef struct packed {
    logic           en;
    logic [9:0]     x;
    logic [9:0]     y;
    logic [FRW-1:0] frame;
    logic           flip;
  } attr_t;

  attr_t pend_q [NSPR];
  attr_t pend_d [NSPR];
  attr_t act_q  [NSPR];
  attr_t act_d  [NSPR];

  logic [10:0]     dx [NSPR];
  logic [10:0]     dy [NSPR];
  logic [NSPR-1:0] hit;
  logic [SELW-1:0] win;
  logic            any_hit;
  logic [WB-1:0]   lx;

  logic            any_hit_q, blk_q;
  logic [CW-1:0]   vga_dat_q, vga_dat_d;
  logic [NSPR-1:0] acc_q, acc_d, coll_q, coll_d, coll_term;

  // Active set swaps from pre-edge pending contents, so a same-cycle write waits a frame.
  always_comb begin
    for (int i = 0; i < NSPR; i++) begin
      pend_d[i] = pend_q[i];
      act_d[i]  = vga_end ? pend_q[i] : act_q[i];
    end
    if (cfg_we && (int'(cfg_sel) < NSPR)) begin
      pend_d[cfg_sel] = '{en: cfg_en, x: cfg_x, y: cfg_y, frame: cfg_frame, flip: cfg_flip};
    end
  end

  // 11-bit offsets make off-screen (negative) positions fail the range test instead of wrapping.
  always_comb begin
    for (int i = 0; i < NSPR; i++) begin
      dx[i]  = {1'b0, pixel_x} + {1'b0, bg_pos} - {1'b0, act_q[i].x};
      dy[i]  = {1'b0, pixel_y} - {1'b0, act_q[i].y};
      hit[i] = act_q[i].en & vga_block & (dx[i] < 11'(SPR_W)) & (dy[i] < 11'(SPR_H));
    end
  end

  always_comb begin
    win     = '0;
    any_hit = 1'b0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win     = SELW'(i);
        any_hit = 1'b1;
      end
    end
    lx      = act_q[win].flip ? ~dx[win][WB-1:0] : dx[win][WB-1:0];
    rom_adr = any_hit ? {act_q[win].frame, dy[win][HB-1:0], lx} : '0;
  end

  always_comb begin
    if (!blk_q) begin
      vga_dat_d = '0;
    end else if (any_hit_q && (rom_dat != CW'(KEY))) begin
      vga_dat_d = rom_dat;
    end else begin
      vga_dat_d = vram_dat;
    end
  end

  always_comb begin
    coll_term = '0;
    for (int i = 1; i < NSPR; i++) begin
      coll_term[i] = hit[0] & hit[i];
    end
    acc_d  = acc_q | coll_term;
    coll_d = coll_q;
    if (vga_end) begin
      coll_d = acc_q | coll_term;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (RST) begin
      for (int i = 0; i < NSPR; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      any_hit_q <= 1'b0;
      blk_q     <= 1'b0;
      vga_dat_q <= '0;
      acc_q     <= '0;
      coll_q    <= '0;
    end else begin
      for (int i = 0; i < NSPR; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
      any_hit_q <= any_hit;
      blk_q     <= vga_block;
      vga_dat_q <= vga_dat_d;
      acc_q     <= acc_d;
      coll_q    <= coll_d;
    end
  end

  assign vga_dat    = vga_dat_q;
  assign coll_flags = coll_q;

endmodule
